// File: rtl/ram_dp_param_pkg.sv
// Shared types, constants and helpers for the parametrised dual-port RAM.
package ram_pkg;

  // Controller states: zero-filling the array, or serving reads/writes.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Same-address read-during-write behaviour selectors.
  localparam int RDW_READ_FIRST    = 0;
  localparam int RDW_WRITE_THROUGH = 1;

  // Number of byte lanes in a word of data_w bits.
  function automatic int be_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/ram_dp_param_if.sv
// Write/read port bundle of the dual-port RAM.
interface ram_dp_param_if
  import ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  localparam int BE_W = be_count(DATA_W);

  logic              clr;
  logic              ready;
  logic              we;
  logic [BE_W-1:0]   be;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  modport master (
    output clr, we, be, waddr, wdata, re, raddr,
    input  ready, rdata, rvalid
  );

  modport slave (
    input  clr, we, be, waddr, wdata, re, raddr,
    output ready, rdata, rvalid
  );
endinterface

// File: rtl/ram_rd_pipe.sv
// RD_LAT-stage {valid, data} shift register for the RAM read path.
// Data stages only load when their incoming valid is set, so the output
// holds the last returned word between reads.
module ram_rd_pipe #(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);
  logic              valid_q [RD_LAT];
  logic [DATA_W-1:0] data_q  [RD_LAT];

  // Shift the read result along the pipeline; reset flushes every stage.
  // NOTE: state registers use non-blocking (<=) so all stages update from
  // pre-edge values, giving a true shift instead of a fall-through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RD_LAT; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      if (valid_i) data_q[0] <= data_i;
      for (int k = 1; k < RD_LAT; k++) begin
        valid_q[k] <= valid_q[k-1];
        if (valid_q[k-1]) data_q[k] <= data_q[k-1];
      end
    end
  end

  assign valid_o = valid_q[RD_LAT-1];
  assign data_o  = data_q[RD_LAT-1];
endmodule

// File: rtl/ram_dp_param.sv
// Simple-dual-port RAM with byte-enable writes, pipelined reads and a
// self-clearing zero-fill controller that runs after reset or on clr.
module ram_dp_param
  import ram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = RDW_READ_FIRST
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_dp_param_if.slave bus
);
  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam int                BE_W      = be_count(DATA_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged_word;
  logic [DATA_W-1:0] rd_word;

  assign ready = (state_q == ST_RUN);
  assign wr_en = ready & bus.we;
  assign rd_en = ready & bus.re;

  // Controller state and clear-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: sweep every address while clearing, restart on clr.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Byte-enable merge of new write data over the currently stored word.
  always_comb begin
    old_word    = mem[bus.waddr];
    merged_word = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (bus.be[i]) merged_word[8*i +: 8] = bus.wdata[8*i +: 8];
    end
  end

  // Read source: stored word, or the merged write word in write-through mode.
  always_comb begin
    rd_word = mem[bus.raddr];
    if (RDW_MODE == RDW_WRITE_THROUGH && wr_en && (bus.waddr == bus.raddr)) begin
      rd_word = merged_word;
    end
  end

  // Array update: zero-fill sweep has priority over user writes.
  // NOTE: the array has no reset; the clear sweep initialises it instead,
  // which keeps it mappable onto RAM macros.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[cnt_q] <= '0;
    end else if (wr_en) begin
      mem[bus.waddr] <= merged_word;
    end
  end

  ram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (rd_en),
    .data_i  (rd_word),
    .valid_o (bus.rvalid),
    .data_o  (bus.rdata)
  );

  assign bus.ready = ready;
endmodule

// File: tb/tb_ram_dp_param.sv
// Directed bench for ram_dp_param: two instances, A (RD_LAT=1, read-first)
// and B (RD_LAT=2, write-through), driven with identical stimulus.
module tb_ram_dp_param;
  import ram_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  ram_dp_param_if #(.DATA_W(16), .ADDR_W(4)) if_a ();
  ram_dp_param_if #(.DATA_W(16), .ADDR_W(4)) if_b ();

  ram_dp_param #(
    .DATA_W(16), .ADDR_W(4), .RD_LAT(1), .RDW_MODE(RDW_READ_FIRST)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a.slave)
  );

  ram_dp_param #(
    .DATA_W(16), .ADDR_W(4), .RD_LAT(2), .RDW_MODE(RDW_WRITE_THROUGH)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] be, input logic [3:0] waddr,
                       input logic [15:0] wdata, input logic re, input logic [3:0] raddr,
                       input logic clr);
    if_a.we = we; if_a.be = be; if_a.waddr = waddr; if_a.wdata = wdata;
    if_a.re = re; if_a.raddr = raddr; if_a.clr = clr;
    if_b.we = we; if_b.be = be; if_b.waddr = waddr; if_b.wdata = wdata;
    if_b.re = re; if_b.raddr = raddr; if_b.clr = clr;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 4'h0, 16'h0000, 1'b0, 4'h0, 1'b0);
  endtask

  // Counts edges until ready rises (bounded) and compares with exp.
  task automatic wait_ready(input string tag, input int exp);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!if_a.ready && n < 40);
    check(tag, 32'(n), 32'(exp));
    check({tag, "_b"}, 32'(if_b.ready), 32'd1);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [15:0] data, input logic [1:0] be);
    @(negedge clk);
    drive(1'b1, be, addr, data, 1'b0, 4'h0, 1'b0);
    @(posedge clk); #1;
    idle();
  endtask

  // Single read: A returns after one edge, B after two; A must hold its data.
  task automatic rd(input string tag, input logic [3:0] addr,
                    input logic [15:0] exp_a, input logic [15:0] exp_b);
    @(negedge clk);
    drive(1'b0, 2'b00, 4'h0, 16'h0000, 1'b1, addr, 1'b0);
    @(posedge clk); #1;
    idle();
    check({tag, "_a_vld"}, 32'(if_a.rvalid), 32'd1);
    check({tag, "_a_data"}, 32'(if_a.rdata), 32'(exp_a));
    check({tag, "_b_vld0"}, 32'(if_b.rvalid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_a_vld_drop"}, 32'(if_a.rvalid), 32'd0);
    check({tag, "_a_hold"}, 32'(if_a.rdata), 32'(exp_a));
    check({tag, "_b_vld"}, 32'(if_b.rvalid), 32'd1);
    check({tag, "_b_data"}, 32'(if_b.rdata), 32'(exp_b));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    idle();

    // Reset state
    #12;
    check("rst_ready_a", 32'(if_a.ready), 32'd0);
    check("rst_rvalid_a", 32'(if_a.rvalid), 32'd0);
    check("rst_rdata_a", 32'(if_a.rdata), 32'd0);
    check("rst_rvalid_b", 32'(if_b.rvalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("init_clear_cycles", 16);

    // Back-to-back reads of the freshly cleared array
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(1'b0, 2'b00, 4'h0, 16'h0000, 1'b1, 4'(i), 1'b0);
      @(posedge clk); #1;
      check("zero_a_vld", 32'(if_a.rvalid), 32'd1);
      check("zero_a_data", 32'(if_a.rdata), 32'h0);
      if (i > 0) begin
        check("zero_b_vld", 32'(if_b.rvalid), 32'd1);
        check("zero_b_data", 32'(if_b.rdata), 32'h0);
      end
    end
    idle();
    @(posedge clk); #1;
    check("zero_a_end", 32'(if_a.rvalid), 32'd0);
    check("zero_b_last", 32'(if_b.rvalid), 32'd1);

    // Byte-enable merge
    wr(4'd3, 16'hBEEF, 2'b11);
    wr(4'd3, 16'h1234, 2'b01);
    rd("be_merge", 4'd3, 16'hBE34, 16'hBE34);
    wr(4'd3, 16'h99AA, 2'b00);
    rd("be_none", 4'd3, 16'hBE34, 16'hBE34);

    // Pipelined reads: A one edge later, B two edges later
    wr(4'd1, 16'hAAAA, 2'b11);
    wr(4'd2, 16'h5555, 2'b11);
    wr(4'd3, 16'h0F0F, 2'b11);
    @(negedge clk);
    drive(1'b0, 2'b00, 4'h0, 16'h0000, 1'b1, 4'd1, 1'b0);
    @(posedge clk); #1;
    check("pipe1_a", 32'(if_a.rdata), 32'hAAAA);
    check("pipe1_b_vld", 32'(if_b.rvalid), 32'd0);
    @(negedge clk);
    drive(1'b0, 2'b00, 4'h0, 16'h0000, 1'b1, 4'd2, 1'b0);
    @(posedge clk); #1;
    check("pipe2_a", 32'(if_a.rdata), 32'h5555);
    check("pipe2_b_vld", 32'(if_b.rvalid), 32'd1);
    check("pipe2_b", 32'(if_b.rdata), 32'hAAAA);
    @(negedge clk);
    drive(1'b0, 2'b00, 4'h0, 16'h0000, 1'b1, 4'd3, 1'b0);
    @(posedge clk); #1;
    idle();
    check("pipe3_a", 32'(if_a.rdata), 32'h0F0F);
    check("pipe3_b_vld", 32'(if_b.rvalid), 32'd1);
    check("pipe3_b", 32'(if_b.rdata), 32'h5555);
    @(posedge clk); #1;
    check("pipe4_a_vld", 32'(if_a.rvalid), 32'd0);
    check("pipe4_b_vld", 32'(if_b.rvalid), 32'd1);
    check("pipe4_b", 32'(if_b.rdata), 32'h0F0F);
    @(posedge clk); #1;
    check("pipe5_b_vld", 32'(if_b.rvalid), 32'd0);
    check("pipe5_b_hold", 32'(if_b.rdata), 32'h0F0F);

    // Read-during-write, same address: A read-first, B write-through
    wr(4'd5, 16'h1111, 2'b11);
    @(negedge clk);
    drive(1'b1, 2'b11, 4'd5, 16'h2222, 1'b1, 4'd5, 1'b0);
    @(posedge clk); #1;
    idle();
    check("rdw_full_a", 32'(if_a.rdata), 32'h1111);
    @(posedge clk); #1;
    check("rdw_full_b", 32'(if_b.rdata), 32'h2222);
    @(negedge clk);
    drive(1'b1, 2'b01, 4'd5, 16'h33CC, 1'b1, 4'd5, 1'b0);
    @(posedge clk); #1;
    idle();
    check("rdw_part_a", 32'(if_a.rdata), 32'h2222);
    @(posedge clk); #1;
    check("rdw_part_b", 32'(if_b.rdata), 32'h22CC);
    @(negedge clk);
    drive(1'b1, 2'b11, 4'd6, 16'h7777, 1'b1, 4'd5, 1'b0);
    @(posedge clk); #1;
    idle();
    check("rdw_diff_a", 32'(if_a.rdata), 32'h22CC);
    @(posedge clk); #1;
    check("rdw_diff_b", 32'(if_b.rdata), 32'h22CC);
    rd("after_rdw", 4'd6, 16'h7777, 16'h7777);

    // clr with a read of addr 7 in the same cycle, junk traffic during clear
    wr(4'd7, 16'hCAFE, 2'b11);
    @(negedge clk);
    drive(1'b0, 2'b00, 4'h0, 16'h0000, 1'b1, 4'd7, 1'b1);
    @(posedge clk); #1;
    idle();
    check("clr_a_vld", 32'(if_a.rvalid), 32'd1);
    check("clr_a_data", 32'(if_a.rdata), 32'hCAFE);
    check("clr_ready_low", 32'(if_a.ready), 32'd0);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        drive(1'b1, 2'b11, 4'd0, 16'hFFFF, 1'b1, 4'd7, 1'b0);
        @(posedge clk); #1;
        n++;
        if (!if_a.ready || n == 16) begin
          check("clr_a_no_vld", 32'(if_a.rvalid), 32'd0);
          if (n == 1) begin
            check("clr_b_inflight", 32'(if_b.rdata), 32'hCAFE);
            check("clr_b_inflight_vld", 32'(if_b.rvalid), 32'd1);
          end else begin
            check("clr_b_no_vld", 32'(if_b.rvalid), 32'd0);
          end
        end
      end while (!if_a.ready && n < 40);
      idle();
      check("clr_cycles", 32'(n), 32'd16);
    end
    @(posedge clk); #1;
    check("clr_post_b_no_vld", 32'(if_b.rvalid), 32'd0);
    rd("clr_addr7", 4'd7, 16'h0000, 16'h0000);
    rd("clr_addr0", 4'd0, 16'h0000, 16'h0000);

    // Reset during a read in flight
    wr(4'd9, 16'hABCD, 2'b11);
    @(negedge clk);
    drive(1'b0, 2'b00, 4'h0, 16'h0000, 1'b1, 4'd9, 1'b0);
    @(posedge clk); #1;
    idle();
    check("midrd_a_data", 32'(if_a.rdata), 32'hABCD);
    rst_n = 1'b0;
    #1;
    check("midrd_a_vld", 32'(if_a.rvalid), 32'd0);
    check("midrd_a_rdata", 32'(if_a.rdata), 32'h0);
    check("midrd_b_vld", 32'(if_b.rvalid), 32'd0);
    check("midrd_ready", 32'(if_a.ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("midrd_clear_cycles", 16);

    // Reset during a clear sweep at cnt=9, with non-zero rdata held
    wr(4'd9, 16'h5A5A, 2'b11);
    rd("pre_midclr", 4'd9, 16'h5A5A, 16'h5A5A);
    @(negedge clk);
    drive(1'b0, 2'b00, 4'h0, 16'h0000, 1'b0, 4'h0, 1'b1);
    @(posedge clk); #1;
    idle();
    repeat (9) @(posedge clk);
    #1;
    check("midclr_still_clear", 32'(if_a.ready), 32'd0);
    check("midclr_hold_a", 32'(if_a.rdata), 32'h5A5A);
    rst_n = 1'b0;
    #1;
    check("midclr_a_rdata", 32'(if_a.rdata), 32'h0);
    check("midclr_b_rdata", 32'(if_b.rdata), 32'h0);
    check("midclr_b_vld", 32'(if_b.rvalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("midclr_clear_cycles", 16);
    rd("post_reset_addr9", 4'd9, 16'h0000, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/ram_dp_param.md
# ram_dp_param

Parametrised simple-dual-port synchronous RAM: one write port with byte enables, one independent read port with configurable read latency and a valid strobe. It adds a self-clearing state machine that zero-fills the array after reset or on request. It is the general-purpose storage block for the design, replacing the fixed 16×8 single-port RAM.

## Interface

- DATA_W, 8: word width in bits. Must be a multiple of 8.
- ADDR_W, 4: address width; DEPTH = 2**ADDR_W words.
- RD_LAT, 1: read latency in clock edges, legal values 1 or 2.
- RDW_MODE, 0: same-address read-during-write behaviour. 0 = read-first (old data); 1 = write-through (new merged data).

Ports:

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  request a zero-fill of the whole array. Sampled only when ready=1.
- ready  out  1  array usable. Low while clearing.
- we  in  1  write strobe.
- be  in  DATA_W/8  byte enables; be[i] covers wdata[8i+7:8i].
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- re  in  1  read strobe.
- raddr  in  ADDR_W  read address.
- rdata  out  DATA_W  read data. Holds its last value when rvalid=0.
- rvalid  out  1  rdata carries the result of a read issued RD_LAT edges earlier.

## Operation

- FSM states: CLEAR and RUN.
  - rst_n low puts the FSM in CLEAR with clear counter = 0. Outputs: ready=0, rvalid=0, rdata=0, read pipeline flushed.
  - The array itself is not reset.
- CLEAR:
  - Each edge writes 0 to mem[cnt], then cnt increments.
  - On the edge that writes address DEPTH-1, the FSM moves to RUN.
  - ready=1 from the following cycle. Total: DEPTH cycles from reset release to ready=1.
  - we, re and clr are ignored; no rvalid is generated for them.
- RUN:
  - ready=1.
  - clr=1 moves the FSM to CLEAR with cnt=0 on the next edge.
  - A we/re presented in the same cycle as clr is still accepted.
- Write: on an edge with we=1 and ready=1, mem[waddr] byte i is updated only where be[i]=1. we=1 with be=0 is a no-op.
- Read: an edge with re=1 and ready=1 launches a read of raddr.
  - Result appears after RD_LAT edges with rvalid=1 for exactly one cycle per read.
  - Back-to-back reads are fully pipelined: one per cycle.
- Read-during-write, same address, same edge:
  - RDW_MODE=0 returns the pre-write word.
  - RDW_MODE=1 returns the word after the byte-enable merge.
  - Different addresses never interact.
- Reads in flight when clr is accepted complete normally with pre-clear data.
- Reads launched in the clr cycle return pre-clear data.

## Timing

- Reset: asynchronous assert; synchronous-edge behaviour from the first rising clk after rst_n rises.
- Reset mid-clear or mid-read:
  - The FSM restarts at CLEAR, cnt=0.
  - The pipeline is flushed: rvalid=0 immediately.
- Read, RD_LAT=1: re at edge N gives rdata/rvalid valid after edge N+1's setup window, i.e. in the cycle following edge N.
- Read, RD_LAT=2: valid one cycle later than RD_LAT=1. The intermediate stage is a register.
- Write data is visible to reads launched on the following edge with either RDW_MODE.
- ready falls in the cycle after the clr edge.
- Addresses are treated modulo DEPTH. There are no out-of-range conditions.

## Structure

- Package ram_pkg holds:
  - the state enum (ST_CLEAR, ST_RUN);
  - the RDW_MODE constants (RDW_READ_FIRST=0, RDW_WRITE_THROUGH=1);
  - the helper function computing the byte-enable count from DATA_W.
- Sub-module ram_rd_pipe: RD_LAT-stage shift register carrying {valid, data}. It has asynchronous flush on rst_n.
- The top level contains the array, the write merge, the RDW bypass mux, the FSM and the clear counter.

## Test plan

- Reset release, DATA_W=16, ADDR_W=4 -> ready=0 for exactly 16 cycles, then 1. Reading addresses 0..15 returns 16'h0000 with rvalid, one per cycle.
- Write 16'hBEEF to addr 3 with be=2'b11, then write 16'h1234 to addr 3 with be=2'b01 -> reading addr 3 returns 16'hBE34.
- RD_LAT=2: back-to-back re to addrs 1, 2, 3 holding 16'hAAAA, 16'h5555, 16'h0F0F -> rvalid high on 3 consecutive cycles, starting 2 cycles after the first re, with data in order.
- Same-edge we and re to addr 5 (old 16'h1111, new 16'h2222, be=2'b11):
  - RDW_MODE=0 -> rdata=16'h1111;
  - RDW_MODE=1 -> rdata=16'h2222.
- clr pulse in RUN with data at addr 7 = 16'hCAFE:
  - a read of addr 7 in the clr cycle returns 16'hCAFE;
  - ready is low for 16 cycles;
  - we/re during the clear produce no writes and no rvalid;
  - afterwards addr 7 reads 16'h0000.
- rst_n asserted mid-clear (cnt=9) and mid-read -> rvalid=0 and rdata=0 immediately; a fresh 16-cycle clear follows release.
